// File: rtl/lbist_pkg.sv
// lbist_pkg: shared FSM state encoding and popcount helper for the LBIST signature checker
//   ST_IDLE/ST_RUN/ST_DONE  session states
//   popcount()              number of set bits in a vector of up to POP_MAX bits
package lbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int POP_MAX = 256;

    function automatic logic [8:0] popcount(input logic [POP_MAX-1:0] v);
        popcount = '0;
        for (int i = 0; i < POP_MAX; i++)
            popcount = popcount + 9'(v[i]);
    endfunction

endpackage

// File: rtl/lbist_popcount.sv
// lbist_popcount: combinational Hamming weight of a WIDTH-bit vector
//   vec  in   WIDTH  vector to count
//   cnt  out  DW     number of ones in vec
module lbist_popcount
    import lbist_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [DW-1:0]    cnt
);

    // Zero-extended into the package helper; the result always fits DW bits.
    assign cnt = DW'(popcount(POP_MAX'(vec)));

endmodule

// File: rtl/lbist_sig_checker.sv
// lbist_sig_checker: compares expected vs captured MISR signatures over a session and issues a verdict
//   CLK, RST          clock, synchronous active-high reset
//   START             begin a session (ignored while running)
//   CMP_VALID/READY   compare handshake, SIG_EXP/SIG_ACT the pair
//   DIST_VALID        strobe two cycles after accept with DIST, REJECT, RED_SIG
//   TOTAL_ERR, FAIL_CNT, MAX_DIST  session statistics
//   BUSY, DONE, PASS  session status and verdict
module lbist_sig_checker
    import lbist_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int THRESH   = 2,
    parameter int NUM_SIG  = 16,
    parameter int MAX_FAIL = 0,
    parameter int CW       = 16,
    localparam int DW      = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             CMP_VALID,
    output logic             CMP_READY,
    input  logic [WIDTH-1:0] SIG_EXP,
    input  logic [WIDTH-1:0] SIG_ACT,
    output logic             DIST_VALID,
    output logic [DW-1:0]    DIST,
    output logic             REJECT,
    output logic [WIDTH-1:0] RED_SIG,
    output logic [CW-1:0]    TOTAL_ERR,
    output logic [CW-1:0]    FAIL_CNT,
    output logic [DW-1:0]    MAX_DIST,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS
);

    localparam int AW = $clog2(NUM_SIG + 1);

    state_t           state;
    logic [AW-1:0]    acc_cnt;
    logic [AW-1:0]    str_cnt;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_act;
    logic [WIDTH-1:0] s1_diff;
    logic [DW-1:0]    pop;
    logic             rej_now;
    logic             accept;
    logic             last_strobe;
    logic [CW:0]      err_sum;
    logic [CW-1:0]    fail_nxt;

    lbist_popcount #(.WIDTH(WIDTH), .DW(DW)) u_pop (
        .vec (s1_diff),
        .cnt (pop)
    );

    assign CMP_READY   = (state == ST_RUN) && (acc_cnt < AW'(NUM_SIG));
    assign accept      = CMP_VALID & CMP_READY;
    assign BUSY        = state == ST_RUN;
    assign rej_now     = pop > DW'(THRESH);
    assign last_strobe = DIST_VALID && (str_cnt == AW'(NUM_SIG - 1));
    // One extra bit catches the carry so the total can clamp at all-ones.
    assign err_sum     = {1'b0, TOTAL_ERR} + (CW + 1)'(DIST);
    assign fail_nxt    = (REJECT && FAIL_CNT != '1) ? FAIL_CNT + 1'b1 : FAIL_CNT;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid   <= 1'b0;
            s1_act     <= '0;
            s1_diff    <= '0;
            DIST_VALID <= 1'b0;
            DIST       <= '0;
            REJECT     <= 1'b0;
            RED_SIG    <= '0;
        end else begin
            s1_valid   <= accept;
            DIST_VALID <= s1_valid;
            if (accept) begin
                s1_act  <= SIG_ACT;
                s1_diff <= SIG_EXP ^ SIG_ACT;
            end
            if (s1_valid) begin
                DIST    <= pop;
                REJECT  <= rej_now;
                RED_SIG <= rej_now ? '0 : s1_act;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            acc_cnt   <= '0;
            str_cnt   <= '0;
            TOTAL_ERR <= '0;
            FAIL_CNT  <= '0;
            MAX_DIST  <= '0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
        end else if (state != ST_RUN) begin
            if (START) begin
                state     <= ST_RUN;
                acc_cnt   <= '0;
                str_cnt   <= '0;
                TOTAL_ERR <= '0;
                FAIL_CNT  <= '0;
                MAX_DIST  <= '0;
                DONE      <= 1'b0;
                PASS      <= 1'b0;
            end
        end else begin
            if (accept)
                acc_cnt <= acc_cnt + 1'b1;
            if (DIST_VALID) begin
                str_cnt   <= str_cnt + 1'b1;
                TOTAL_ERR <= err_sum[CW] ? '1 : err_sum[CW-1:0];
                FAIL_CNT  <= fail_nxt;
                MAX_DIST  <= (DIST > MAX_DIST) ? DIST : MAX_DIST;
            end
            // The verdict must include the reject carried by the final strobe.
            if (last_strobe) begin
                state <= ST_DONE;
                DONE  <= 1'b1;
                PASS  <= fail_nxt <= CW'(MAX_FAIL);
            end
        end
    end

endmodule

// File: tb/tb_lbist_sig_checker.sv
// tb_lbist_sig_checker: session-level model plus directed checks for lbist_sig_checker
module tb_lbist_sig_checker;

    localparam int WIDTH    = 8;
    localparam int THRESH   = 2;
    localparam int NUM_SIG  = 16;
    localparam int MAX_FAIL = 0;
    localparam int CW       = 16;
    localparam int DW       = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             START = 1'b0;
    logic             CMP_VALID = 1'b0;
    logic             CMP_READY;
    logic [WIDTH-1:0] SIG_EXP = '0;
    logic [WIDTH-1:0] SIG_ACT = '0;
    logic             DIST_VALID;
    logic [DW-1:0]    DIST;
    logic             REJECT;
    logic [WIDTH-1:0] RED_SIG;
    logic [CW-1:0]    TOTAL_ERR;
    logic [CW-1:0]    FAIL_CNT;
    logic [DW-1:0]    MAX_DIST;
    logic             BUSY;
    logic             DONE;
    logic             PASS;

    lbist_sig_checker #(
        .WIDTH(WIDTH), .THRESH(THRESH), .NUM_SIG(NUM_SIG), .MAX_FAIL(MAX_FAIL), .CW(CW)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .CMP_VALID(CMP_VALID), .CMP_READY(CMP_READY),
        .SIG_EXP(SIG_EXP), .SIG_ACT(SIG_ACT), .DIST_VALID(DIST_VALID), .DIST(DIST),
        .REJECT(REJECT), .RED_SIG(RED_SIG), .TOTAL_ERR(TOTAL_ERR), .FAIL_CNT(FAIL_CNT),
        .MAX_DIST(MAX_DIST), .BUSY(BUSY), .DONE(DONE), .PASS(PASS)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a session is a count of accepted pairs and a list of results
    // that each appear exactly two cycles after their pair was accepted.
    typedef struct {
        int         due;
        int         d;
        bit         rej;
        logic [7:0] red;
    } rec_t;

    rec_t       q[$];
    int         cyc = 0;
    bit         armed = 0;
    bit         running = 0, m_done = 0, m_pass = 0;
    int         accepted = 0, strobes = 0;
    int         m_total = 0, m_fail = 0, m_max = 0;
    int         m_dist = 0;
    bit         m_rej = 0;
    logic [7:0] m_red = '0;

    always @(negedge CLK) begin
        bit   strobe;
        bit   ready;
        bit   was_running;
        rec_t r;
        cyc++;
        strobe = q.size() > 0 && q[0].due == cyc;
        if (strobe) begin
            r = q.pop_front();
            m_dist = r.d;
            m_rej  = r.rej;
            m_red  = r.red;
        end
        ready = running && accepted < NUM_SIG;
        if (armed) begin
            chk("dist_valid", 32'(DIST_VALID), 32'(strobe));
            chk("dist", 32'(DIST), 32'(m_dist));
            chk("reject", 32'(REJECT), 32'(m_rej));
            chk("red_sig", 32'(RED_SIG), 32'(m_red));
            chk("cmp_ready", 32'(CMP_READY), 32'(ready));
            chk("busy", 32'(BUSY), 32'(running));
            chk("done", 32'(DONE), 32'(m_done));
            chk("pass", 32'(PASS), 32'(m_pass));
            chk("total_err", 32'(TOTAL_ERR), 32'(m_total));
            chk("fail_cnt", 32'(FAIL_CNT), 32'(m_fail));
            chk("max_dist", 32'(MAX_DIST), 32'(m_max));
        end
        if (RST) begin
            armed = 1; q.delete();
            running = 0; m_done = 0; m_pass = 0;
            accepted = 0; strobes = 0;
            m_total = 0; m_fail = 0; m_max = 0;
            m_dist = 0; m_rej = 0; m_red = '0;
        end else begin
            was_running = running;
            if (strobe && running) begin
                m_total = (m_total + r.d > 65535) ? 65535 : m_total + r.d;
                if (r.rej) m_fail = (m_fail == 65535) ? 65535 : m_fail + 1;
                if (r.d > m_max) m_max = r.d;
                strobes++;
                if (strobes == NUM_SIG) begin
                    running = 0;
                    m_done  = 1;
                    m_pass  = m_fail <= MAX_FAIL;
                end
            end
            if (!was_running && START) begin
                running = 1; m_done = 0; m_pass = 0;
                accepted = 0; strobes = 0;
                m_total = 0; m_fail = 0; m_max = 0;
            end
            if (ready && CMP_VALID) begin
                r.due = cyc + 2;
                r.d   = $countones(SIG_EXP ^ SIG_ACT);
                r.rej = r.d > THRESH;
                r.red = r.rej ? 8'h00 : SIG_ACT;
                q.push_back(r);
                accepted++;
            end
        end
    end

    int run_len = 0;
    int max_run = 0;

    always @(negedge CLK) begin
        run_len = DIST_VALID ? run_len + 1 : 0;
        if (run_len > max_run) max_run = run_len;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic send(input logic [7:0] e, input logic [7:0] a);
        int n;
        bit ok;
        n = 0;
        ok = 0;
        CMP_VALID = 1'b1;
        SIG_EXP = e;
        SIG_ACT = a;
        while (!ok && n < 50) begin
            @(negedge CLK);
            ok = CMP_READY;
            tick();
            n++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got ready=0 expected ready=1 at %0t", $time);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (DONE !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("wait_done", 32'(DONE), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_ready", 32'(CMP_READY), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        tick();

        // CMP_VALID held in IDLE is ignored
        CMP_VALID = 1'b1; SIG_EXP = 8'h12; SIG_ACT = 8'h34;
        repeat (3) tick();
        CMP_VALID = 1'b0;

        // Session 1: identical pairs, back-to-back
        pulse_start();
        max_run = 0;
        for (int i = 0; i < NUM_SIG; i++) send(8'hA5, 8'hA5);
        CMP_VALID = 1'b0;
        wait_done();
        chk("s1_pass", 32'(PASS), 32'd1);
        chk("s1_red", 32'(RED_SIG), 32'hA5);
        chk("s1_dist", 32'(DIST), 32'd0);
        chk("s1_total", 32'(TOTAL_ERR), 32'd0);
        chk("s1_run", 32'(max_run), 32'd16);
        tick();

        // CMP_VALID held in DONE is ignored
        CMP_VALID = 1'b1;
        repeat (4) tick();
        CMP_VALID = 1'b0;

        // Session 2: threshold boundary pairs
        pulse_start();
        send(8'hFF, 8'hFC);
        CMP_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("fc_valid", 32'(DIST_VALID), 32'd1);
        chk("fc_dist", 32'(DIST), 32'd2);
        chk("fc_reject", 32'(REJECT), 32'd0);
        chk("fc_red", 32'(RED_SIG), 32'hFC);
        tick();
        send(8'hFF, 8'hF8);
        CMP_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("f8_valid", 32'(DIST_VALID), 32'd1);
        chk("f8_dist", 32'(DIST), 32'd3);
        chk("f8_reject", 32'(REJECT), 32'd1);
        chk("f8_red", 32'(RED_SIG), 32'h00);
        tick();
        for (int i = 0; i < NUM_SIG - 2; i++) send(8'hA5, 8'hA5);
        CMP_VALID = 1'b0;
        wait_done();
        chk("s2_total", 32'(TOTAL_ERR), 32'd5);
        chk("s2_fail", 32'(FAIL_CNT), 32'd1);
        chk("s2_max", 32'(MAX_DIST), 32'd3);
        chk("s2_pass", 32'(PASS), 32'd0);
        tick();

        // Session 3: one fully inverted signature
        pulse_start();
        for (int i = 0; i < NUM_SIG; i++) send(i == 7 ? 8'h00 : 8'hA5, i == 7 ? 8'hFF : 8'hA5);
        CMP_VALID = 1'b0;
        wait_done();
        chk("s3_total", 32'(TOTAL_ERR), 32'd8);
        chk("s3_fail", 32'(FAIL_CNT), 32'd1);
        chk("s3_max", 32'(MAX_DIST), 32'd8);
        chk("s3_pass", 32'(PASS), 32'd0);
        tick();

        // Session 4: reset after five accepts discards in-flight compares
        pulse_start();
        for (int i = 0; i < 5; i++) send(8'hFF, 8'hFE);
        RST = 1'b1;
        CMP_VALID = 1'b0;
        repeat (2) tick();
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("rst_no_strobe", 32'(DIST_VALID), 32'd0);
        end
        chk("rst_dist", 32'(DIST), 32'd0);
        chk("rst_total", 32'(TOTAL_ERR), 32'd0);
        chk("rst_busy2", 32'(BUSY), 32'd0);
        tick();
        pulse_start();
        max_run = 0;
        for (int i = 0; i < NUM_SIG; i++) send(8'h3C, 8'h3D);
        CMP_VALID = 1'b0;
        wait_done();
        chk("s4_total", 32'(TOTAL_ERR), 32'd16);
        chk("s4_pass", 32'(PASS), 32'd1);
        chk("s4_run", 32'(max_run), 32'd16);
        tick();

        // Session 5: START pulsed mid-run is ignored
        pulse_start();
        for (int i = 0; i < 3; i++) send(8'h0F, 8'h0F);
        START = 1'b1;
        send(8'h0F, 8'h0E);
        START = 1'b0;
        for (int i = 0; i < NUM_SIG - 4; i++) send(8'h0F, 8'h0F);
        CMP_VALID = 1'b0;
        wait_done();
        chk("s5_total", 32'(TOTAL_ERR), 32'd1);
        chk("s5_pass", 32'(PASS), 32'd1);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
